// File: rtl/md_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO and mthi/mtlo.
// Optional MADD/MADDU accumulate ops are enabled by defining MD_MADD_EN.
module md_unit #(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [3:0]  op,
   input  logic        H_L_sel,
   output logic [31:0] out,
   output logic        busy
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd8;
   localparam logic [3:0] OP_MADDU = 4'd9;
`endif

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [31:0]   hi_q,    hi_d;
   logic [31:0]   lo_q,    lo_d;
   logic [31:0]   a_q,     a_d;
   logic [31:0]   b_q,     b_d;
   logic [3:0]    op_q,    op_d;

   logic          is_mul, is_div;
   logic [63:0]   mul_s, mul_u, result;
   logic          div_zero, div_ovf;
   logic signed [31:0] sdiv_b, sdiv_quot, sdiv_rem;
   logic [31:0]   udiv_b, udiv_quot, udiv_rem;

   always_comb begin
      is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MD_MADD_EN
      is_mul = is_mul || (op == OP_MADD) || (op == OP_MADDU);
`endif
      is_div = (op == OP_DIV) || (op == OP_DIVU);
   end

   assign mul_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
   assign mul_u = {32'd0, a_q} * {32'd0, b_q};

   // The dividers only ever see a legal divisor; the special cases are muxed in below.
   assign div_zero  = (b_q == 32'd0);
   assign div_ovf   = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
   assign sdiv_b    = (div_zero || div_ovf) ? 32'sd1 : $signed(b_q);
   assign sdiv_quot = $signed(a_q) / sdiv_b;
   assign sdiv_rem  = $signed(a_q) % sdiv_b;
   assign udiv_b    = div_zero ? 32'd1 : b_q;
   assign udiv_quot = a_q / udiv_b;
   assign udiv_rem  = a_q % udiv_b;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      result = {hi_q, lo_q};
      case (op_q)
         OP_MULT:  result = mul_s;
         OP_MULTU: result = mul_u;
         OP_DIV: begin
            if (div_zero)     result = {a_q, 32'hFFFF_FFFF};
            else if (div_ovf) result = {32'd0, 32'h8000_0000};
            else              result = {sdiv_rem, sdiv_quot};
         end
         OP_DIVU: begin
            if (div_zero) result = {a_q, 32'hFFFF_FFFF};
            else          result = {udiv_rem, udiv_quot};
         end
`ifdef MD_MADD_EN
         OP_MADD:  result = {hi_q, lo_q} + mul_s;
         OP_MADDU: result = {hi_q, lo_q} + mul_u;
`endif
         default:  result = {hi_q, lo_q};
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      case (state_q)
         ST_IDLE: begin
            if (is_mul || is_div) begin
               a_d     = A;
               b_d     = B;
               op_d    = op;
               cnt_d   = is_mul ? CW'(MUL_LAT) : CW'(DIV_LAT);
               state_d = ST_RUN;
            end else if (op == OP_MTHI) begin
               hi_d = A;
            end else if (op == OP_MTLO) begin
               lo_d = A;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               {hi_d, lo_d} = result;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign out  = H_L_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (default latencies, MD_MADD_EN optional).
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] A, B;
   logic [3:0]  op;
   logic        H_L_sel;
   logic [31:0] out;
   logic        busy;

   int n_cmp  = 0;
   int n_fail = 0;

   md_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
      .clk     (clk),
      .reset   (reset),
      .A       (A),
      .B       (B),
      .op      (op),
      .H_L_sel (H_L_sel),
      .out     (out),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      logic [31:0] hi;
      logic [31:0] lo;
      string       name;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_hilo(input string nm, input logic [31:0] ehi, input logic [31:0] elo);
      H_L_sel = 1'b1;
      #1 check({nm, " HI"}, out, ehi);
      H_L_sel = 1'b0;
      #1 check({nm, " LO"}, out, elo);
   endtask

   // Issue one op, count busy cycles (bounded), then compare HI/LO.
   task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] ehi, input logic [31:0] elo,
                        input string nm);
      int cnt;
      @(negedge clk);
      op = o; A = a; B = b;
      @(negedge clk);
      op = 4'd0;
      cnt = 0;
      while (busy && cnt < lat + 5) begin
         cnt++;
         @(negedge clk);
      end
      check({nm, " busy cycles"}, 32'(cnt), 32'(lat));
      check_hilo(nm, ehi, elo);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{4'd1, 32'hFFFF_FFFE, 32'd3,          5,  32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult -2*3"};
      vecs[1]  = '{4'd2, 32'hFFFF_FFFF, 32'd2,          5,  32'h0000_0001, 32'hFFFF_FFFE, "multu"};
      vecs[2]  = '{4'd3, 32'hFFFF_FFF9, 32'd2,          10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2"};
      vecs[3]  = '{4'd4, 32'd7,         32'd0,          10, 32'd7,         32'hFFFF_FFFF, "divu 7/0"};
      vecs[4]  = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000, "div ovf"};
      vecs[5]  = '{4'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD, "div 7/-2"};
      vecs[6]  = '{4'd4, 32'hFFFF_FFFF, 32'd16,         10, 32'd15,        32'h0FFF_FFFF, "divu big"};
      vecs[7]  = '{4'd3, 32'd5,         32'd0,          10, 32'd5,         32'hFFFF_FFFF, "div 5/0"};
      vecs[8]  = '{4'd5, 32'h0000_1234, 32'd0,          0,  32'h0000_1234, 32'hFFFF_FFFF, "mthi"};
      vecs[9]  = '{4'd6, 32'h0000_ABCD, 32'd0,          0,  32'h0000_1234, 32'h0000_ABCD, "mtlo"};
      vecs[10] = '{4'd1, 32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'd0,         "mult minmin"};
      vecs[11] = '{4'd0, 32'h5555_5555, 32'd1,          0,  32'h4000_0000, 32'd0,         "nop"};
      vecs[12] = '{4'd7, 32'h5555_5555, 32'd1,          0,  32'h4000_0000, 32'd0,         "op7"};

      reset = 1'b0; A = '0; B = '0; op = '0; H_L_sel = 1'b0;
      repeat (2) @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check_hilo("reset", 32'd0, 32'd0);
      reset = 1'b1;

      for (int i = 0; i < 13; i++)
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].hi, vecs[i].lo, vecs[i].name);

      // mthi during RUN is ignored; out keeps showing pre-op values.
      @(negedge clk);
      op = 4'd6; A = 32'h55;
      @(negedge clk);
      op = 4'd2; A = 32'd3; B = 32'd4;
      @(negedge clk);
      op = 4'd5; A = 32'h1234;
      check("run busy", 32'(busy), 32'd1);
      check_hilo("run pre-op", 32'h4000_0000, 32'h55);
      @(negedge clk);
      op = 4'd0;
      check_hilo("run mthi ignored", 32'h4000_0000, 32'h55);
      begin
         int cnt = 0;
         while (busy && cnt < 10) begin
            cnt++;
            @(negedge clk);
         end
         check("multu 3*4 busy fell", 32'(busy), 32'd0);
      end
      check_hilo("multu 3*4", 32'd0, 32'hC);

      // Reset asserted in the 3rd cycle of a DIV aborts it.
      @(negedge clk);
      op = 4'd3; A = 32'd100; B = 32'd7;
      @(negedge clk);
      op = 4'd0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1 check("abort busy", 32'(busy), 32'd0);
      check_hilo("abort", 32'd0, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      check("after abort busy", 32'(busy), 32'd0);
      check_hilo("after abort", 32'd0, 32'd0);

      do_op(4'd5, 32'd0, 32'd0, 0, 32'd0, 32'd0, "mthi 0");
      do_op(4'd6, 32'd5, 32'd0, 0, 32'd0, 32'd5, "mtlo 5");
`ifdef MD_MADD_EN
      do_op(4'd8, 32'd2,         32'd3,         5, 32'd0,         32'd11,        "madd 2*3");
      do_op(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_000C, "maddu");
      do_op(4'd8, 32'hFFFF_FFFF, 32'd2,         5, 32'hFFFF_FFFE, 32'h0000_000A, "madd -1*2");
`else
      do_op(4'd8, 32'd2, 32'd3, 0, 32'd0, 32'd5, "op8 nop");
      do_op(4'd9, 32'd2, 32'd3, 0, 32'd0, 32'd5, "op9 nop");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit with architectural HI/LO registers for the E stage of the 5-stage MIPS pipeline. It takes the forwarded ALU operands (`A`, `B`), runs mult/multu/div/divu over a fixed number of cycles, and handles mthi/mtlo writes. It always presents HI or LO on `out` for mfhi/mflo. `busy` feeds the hazard logic, which freezes F/D/E while a multi-cycle operation is in flight.

## Interface
Parameters:
- `MUL_LAT`, 5: cycles from mult/multu acceptance to HI/LO update (≥1).
- `DIV_LAT`, 10: cycles from div/divu acceptance to HI/LO update (≥1).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; unit is in reset while `reset`=0.
- `A`  in  32  operand rs (forwarded), also the mthi/mtlo source.
- `B`  in  32  operand rt (forwarded).
- `op`  in  4  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 8 MADD, 9 MADDU; others are NOP.
- `H_L_sel`  in  1  output select: 1 = HI, 0 = LO.
- `out`  out  32  `H_L_sel` ? HI : LO, combinational.
- `busy`  out  1  high while an accepted multi-cycle operation is in progress.

## Operation
- Reset (`reset`=0, asynchronous): HI=0, LO=0, busy=0, counter=0, latched operands cleared. `out`=0.
- States: IDLE, RUN.
- IDLE:
  - `op` ∈ {1,2,3,4,8,9} is accepted at the edge. Operands and op are latched, the counter is loaded with MUL_LAT (1,2,8,9) or DIV_LAT (3,4), and the unit enters RUN.
  - MTHI writes HI←A at the edge. MTLO writes LO←A at the edge. Both take effect in one cycle and `busy` does not rise.
- RUN: the counter decrements every edge. At the edge where the counter reaches 0, HI/LO are written and the unit returns to IDLE.
- Any `op` presented while in RUN is ignored, including MTHI/MTLO. Upstream holds the instruction in E via the stall.
- Arithmetic, computed on the latched operands:
  - MULT: {HI,LO} ← signed A×B (64-bit).
  - MULTU: {HI,LO} ← unsigned A×B (64-bit).
  - DIV: LO ← quotient truncated toward zero, HI ← remainder with the sign of the dividend.
  - DIVU: LO ← unsigned quotient, HI ← unsigned remainder.
- Divide by zero: HI ← A, LO ← 32'hFFFFFFFF. Applies to both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: LO ← 0x80000000, HI ← 0.
- `out` reflects the current HI/LO. During RUN it shows the pre-operation values.

## Timing
- The accepting edge is t0. `busy`=1 from t0 until the edge t0+L (L = MUL_LAT or DIV_LAT), and `busy`=0 after t0+L.
- The new HI/LO are visible on `out` in the cycle after edge t0+L, which is the same cycle `busy` falls.
- The next operation is accepted at edge t0+L+1 at the earliest. There are no back-to-back accepts without one IDLE cycle.
- MTHI/MTLO: written at the edge; `out` shows the new value in the next cycle.
- `busy` is a registered output with no combinational path from `op`. The hazard unit covers the issue cycle by decoding the E-stage op itself.
- When `reset` is asserted mid-RUN, the operation is aborted at once and no HI/LO update occurs.

## Configuration
- `MD_MADD_EN`:
  - Defined: op 8 MADD computes {HI,LO} ← {HI,LO} + signed A×B, and op 9 MADDU does the same unsigned. Both use MUL_LAT timing, and the accumulate uses the HI/LO values held at completion time. Both are mod 2^64.
  - Undefined: ops 8 and 9 are decoded as NOP and never set `busy`.

## Test plan
- Reset, then MULT A=0xFFFFFFFE (−2), B=3: `busy` is high for 5 cycles. Afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=2: HI=0x00000001, LO=0xFFFFFFFE after 5 cycles. During RUN, `out` with `H_L_sel`=0 still shows the previous LO.
- DIV A=−7 (0xFFFFFFF9), B=2: `busy` is high for 10 cycles. Afterwards LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0: HI=7, LO=0xFFFFFFFF.
- MTHI A=0x1234 while in RUN is ignored. MTHI A=0x1234 in IDLE gives `out`=0x1234 with `H_L_sel`=1 in the next cycle and `busy`=0 throughout.
- Pull `reset` low in the 3rd cycle of a DIV: `busy`=0, HI=LO=0 immediately, and no later update occurs.
- With `MD_MADD_EN`: HI:LO=0:5, then MADD A=2, B=3 gives LO=11, HI=0. Without the macro, op 8 leaves `busy`=0 and HI/LO unchanged.
